// File: rtl/dma_burst_gen.sv
// DMA burst generator: splits a {addr, bytes} descriptor into AXI INCR burst
// requests bounded by MAX_BEATS and BOUNDARY, with partial head/tail strobes.
module dma_burst_gen #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 512,
    parameter int LEN_W           = 32,
    parameter int MAX_BEATS       = 256,
    parameter int BOUNDARY        = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                desc_valid_i,
    output logic                desc_ready_o,
    input  logic [ADDR_W-1:0]   desc_addr_i,
    input  logic [LEN_W-1:0]    desc_bytes_i,
    input  logic                abort_i,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic [ADDR_W-1:0]   req_addr_o,
    output logic [7:0]          req_len_o,
    output logic [2:0]          req_size_o,
    output logic [DATA_W/8-1:0] req_first_strb_o,
    output logic [DATA_W/8-1:0] req_last_strb_o,
    output logic                req_last_o,
    input  logic                txn_done_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                aborted_o
);

    localparam int BPB       = DATA_W / 8;
    localparam int SIZE      = $clog2(BPB);
    localparam int LW        = LEN_W + 1;
    localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int BND_BEATS = BOUNDARY / BPB;
    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPLIT,
        ST_DRAIN
    } state_e;

    state_e            state_q;
    logic              desc_ready_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [LW-1:0]     rem_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              abort_seen_q;
    logic              req_valid_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [7:0]        req_len_q;
    logic [BPB-1:0]    req_first_strb_q;
    logic [BPB-1:0]    req_last_strb_q;
    logic              req_last_q;
    logic              done_q;
    logic              aborted_q;

    logic [SIZE-1:0]   off_lo;
    logic [SIZE-1:0]   end_lo;
    logic [LW-1:0]     off_w;
    logic [LW-1:0]     beats_rem;
    logic [LW-1:0]     beats_bnd;
    logic [LW-1:0]     n_beats;
    logic [LW-1:0]     n_bytes;
    logic [LW-1:0]     head_room;
    logic [LW-1:0]     consumed;
    logic [ADDR_W-1:0] abase;
    logic [ADDR_W-1:0] bnd_off;
    logic [BPB-1:0]    first_mask;
    logic [BPB-1:0]    last_mask;

    logic [ADDR_W-1:0] cur_addr_d;
    logic [LW-1:0]     rem_d;
    logic [7:0]        req_len_d;
    logic [BPB-1:0]    req_first_strb_d;
    logic [BPB-1:0]    req_last_strb_d;
    logic              req_last_d;
    logic [CNT_W-1:0]  cnt_d;

    logic              req_hs;
    logic              txn_dec;

    // Next burst, derived from the current address and the bytes still to cover.
    // NOTE: every variable gets a value before any condition, so no latch is inferred.
    always_comb begin
        off_lo    = cur_addr_q[SIZE-1:0];
        off_w     = LW'(off_lo);
        abase     = {cur_addr_q[ADDR_W-1:SIZE], {SIZE{1'b0}}};
        bnd_off   = (abase & ADDR_W'(BOUNDARY - 1)) >> SIZE;
        beats_rem = (off_w + rem_q + LW'(BPB - 1)) >> SIZE;
        beats_bnd = LW'(BND_BEATS) - LW'(bnd_off);

        n_beats = LW'(MAX_BEATS);
        if (beats_rem < n_beats) n_beats = beats_rem;
        if (beats_bnd < n_beats) n_beats = beats_bnd;

        n_bytes   = n_beats << SIZE;
        head_room = n_bytes - off_w;
        consumed  = (head_room < rem_q) ? head_room : rem_q;

        // Whole beats in the middle do not change the tail position within a beat.
        end_lo     = SIZE'(off_w + consumed);
        first_mask = {BPB{1'b1}} << off_lo;
        last_mask  = (end_lo == '0) ? {BPB{1'b1}} : ~({BPB{1'b1}} << end_lo);

        req_len_d        = 8'(n_beats - LW'(1));
        req_first_strb_d = (n_beats == LW'(1)) ? (first_mask & last_mask) : first_mask;
        req_last_strb_d  = (n_beats == LW'(1)) ? (first_mask & last_mask) : last_mask;
        req_last_d       = (rem_q == consumed);
        cur_addr_d       = abase + ADDR_W'(n_bytes);
        rem_d            = rem_q - consumed;
    end

    assign req_hs  = req_valid_q && req_ready_i;
    assign txn_dec = txn_done_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (req_hs && !txn_dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!req_hs && txn_dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            desc_ready_q     <= 1'b0;
            cur_addr_q       <= '0;
            rem_q            <= '0;
            cnt_q            <= '0;
            abort_seen_q     <= 1'b0;
            req_valid_q      <= 1'b0;
            req_addr_q       <= '0;
            req_len_q        <= '0;
            req_first_strb_q <= '0;
            req_last_strb_q  <= '0;
            req_last_q       <= 1'b0;
            done_q           <= 1'b0;
            aborted_q        <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    desc_ready_q <= 1'b1;
                    if (desc_valid_i && desc_ready_q) begin
                        desc_ready_q <= 1'b0;
                        cur_addr_q   <= desc_addr_i;
                        rem_q        <= {1'b0, desc_bytes_i};
                        abort_seen_q <= 1'b0;
                        state_q      <= (desc_bytes_i == '0) ? ST_DRAIN : ST_SPLIT;
                    end
                end
                ST_SPLIT: begin
                    if (req_valid_q) begin
                        // A presented request must finish its handshake even under abort.
                        if (req_ready_i) begin
                            req_valid_q <= 1'b0;
                            if (req_last_q || abort_i || abort_seen_q) begin
                                state_q      <= ST_DRAIN;
                                abort_seen_q <= !req_last_q;
                            end
                        end else if (abort_i) begin
                            abort_seen_q <= 1'b1;
                        end
                    end else if (abort_i) begin
                        state_q      <= ST_DRAIN;
                        abort_seen_q <= 1'b1;
                    end else if (cnt_q < MAX_OUT) begin
                        req_valid_q      <= 1'b1;
                        req_addr_q       <= {cur_addr_q[ADDR_W-1:SIZE], {SIZE{1'b0}}};
                        req_len_q        <= req_len_d;
                        req_first_strb_q <= req_first_strb_d;
                        req_last_strb_q  <= req_last_strb_d;
                        req_last_q       <= req_last_d;
                        cur_addr_q       <= cur_addr_d;
                        rem_q            <= rem_d;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q      <= ST_IDLE;
                        desc_ready_q <= 1'b1;
                        done_q       <= 1'b1;
                        aborted_q    <= abort_seen_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign desc_ready_o     = desc_ready_q;
    assign req_valid_o      = req_valid_q;
    assign req_addr_o       = req_addr_q;
    assign req_len_o        = req_len_q;
    assign req_size_o       = 3'(SIZE);
    assign req_first_strb_o = req_first_strb_q;
    assign req_last_strb_o  = req_last_strb_q;
    assign req_last_o       = req_last_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = done_q;
    assign aborted_o        = aborted_q;

endmodule

// File: tb/tb_dma_burst_gen.sv
// Scoreboard bench for dma_burst_gen: expected bursts and completions are queued
// by the stimulus and consumed by a monitor on every handshake / done pulse.
module tb_dma_burst_gen;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 512;
    localparam int LEN_W   = 32;
    localparam int BPB     = DATA_W / 8;
    localparam int MAX_OUT = 2;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic              clk;
    logic              rst;
    logic              desc_valid_i;
    logic              desc_ready_o;
    logic [ADDR_W-1:0] desc_addr_i;
    logic [LEN_W-1:0]  desc_bytes_i;
    logic              abort_i;
    logic              req_valid_o;
    logic              req_ready_i;
    logic [ADDR_W-1:0] req_addr_o;
    logic [7:0]        req_len_o;
    logic [2:0]        req_size_o;
    logic [BPB-1:0]    req_first_strb_o;
    logic [BPB-1:0]    req_last_strb_o;
    logic              req_last_o;
    logic              txn_done_i;
    logic              busy_o;
    logic              done_o;
    logic              aborted_o;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [63:0] fs;
        logic [63:0] ls;
        logic        last;
    } req_t;

    req_t exp_req[$];
    logic exp_done[$];

    int checks      = 0;
    int failures    = 0;
    int hs_count    = 0;
    int done_count  = 0;
    int done_sent   = 0;
    int grant_total = 0;
    int done_target = 0;
    bit auto_rsp    = 1'b1;

    dma_burst_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .MAX_BEATS(256), .BOUNDARY(4096), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_addr_i(desc_addr_i), .desc_bytes_i(desc_bytes_i),
        .abort_i(abort_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_addr_o(req_addr_o), .req_len_o(req_len_o), .req_size_o(req_size_o),
        .req_first_strb_o(req_first_strb_o), .req_last_strb_o(req_last_strb_o),
        .req_last_o(req_last_o), .txn_done_i(txn_done_i),
        .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic [7:0] l,
                            input logic [63:0] fs, input logic [63:0] ls, input logic last);
        req_t r;
        r.addr = a; r.len = l; r.fs = fs; r.ls = ls; r.last = last;
        exp_req.push_back(r);
    endtask

    task automatic push_done(input logic ab);
        exp_done.push_back(ab);
        done_target++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic grant(input int n);
        grant_total = done_sent + n;
    endtask

    task automatic send_desc(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        desc_valid_i = 1'b1;
        desc_addr_i  = a;
        desc_bytes_i = b;
        n = 0;
        while (!desc_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!desc_ready_o) check("desc_ready_timeout", 64'(desc_ready_o), 64'd1);
        @(posedge clk);
        #1 desc_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_count < done_target && n < 400) begin
            wait_cycles(1);
            n++;
        end
        check("wait_done", 64'(done_count), 64'(done_target));
    endtask

    // Completion responder: one txn_done_i pulse per issued burst, either
    // automatically or only as far as the stimulus has granted.
    initial begin
        txn_done_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                done_sent  = hs_count;
                txn_done_i = 1'b0;
            end else if (done_sent < hs_count && (auto_rsp || done_sent < grant_total)) begin
                txn_done_i = 1'b1;
                done_sent++;
            end else begin
                txn_done_i = 1'b0;
            end
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    bit   stall_q = 1'b0;
    req_t prev;
    always @(negedge clk) begin
        req_t e;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", 64'(req_valid_o), 64'd1);
                check("stall_addr",  64'(req_addr_o), 64'(prev.addr));
                check("stall_len",   64'(req_len_o), 64'(prev.len));
                check("stall_fstrb", req_first_strb_o, prev.fs);
                check("stall_lstrb", req_last_strb_o, prev.ls);
                check("stall_last",  64'(req_last_o), 64'(prev.last));
            end
            if (req_valid_o && req_ready_i) begin
                hs_count++;
                if (exp_req.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got addr 0x%0h required no request", req_addr_o);
                end else begin
                    e = exp_req.pop_front();
                    check("req_addr",  64'(req_addr_o), 64'(e.addr));
                    check("req_len",   64'(req_len_o), 64'(e.len));
                    check("req_fstrb", req_first_strb_o, e.fs);
                    check("req_lstrb", req_last_strb_o, e.ls);
                    check("req_last",  64'(req_last_o), 64'(e.last));
                end
            end
            stall_q   = req_valid_o && !req_ready_i;
            prev.addr = req_addr_o;
            prev.len  = req_len_o;
            prev.fs   = req_first_strb_o;
            prev.ls   = req_last_strb_o;
            prev.last = req_last_o;
            if (done_o) begin
                done_count++;
                if (exp_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done_o=1 required none");
                end else begin
                    check("done_aborted", 64'(aborted_o), 64'(exp_done.pop_front()));
                end
            end
        end
    end

    initial begin
        int base;
        int n;
        rst          = 1'b1;
        desc_valid_i = 1'b0;
        desc_addr_i  = '0;
        desc_bytes_i = '0;
        abort_i      = 1'b0;
        req_ready_i  = 1'b1;

        // Reset state.
        wait_cycles(3);
        check("rst_req_valid",  64'(req_valid_o), 64'd0);
        check("rst_desc_ready", 64'(desc_ready_o), 64'd0);
        check("rst_busy",       64'(busy_o), 64'd0);
        check("rst_done",       64'(done_o), 64'd0);
        check("rst_aborted",    64'(aborted_o), 64'd0);
        check("rst_size",       64'(req_size_o), 64'd6);
        check("rst_addr",       64'(req_addr_o), 64'd0);
        check("rst_fstrb",      req_first_strb_o, 64'd0);
        #1 rst = 1'b0;

        // 16 KB aligned: four 64-beat bursts, one per 4 KB page.
        push_req(32'h1000, 8'd63, ONES, ONES, 1'b0);
        push_req(32'h2000, 8'd63, ONES, ONES, 1'b0);
        push_req(32'h3000, 8'd63, ONES, ONES, 1'b0);
        push_req(32'h4000, 8'd63, ONES, ONES, 1'b1);
        push_done(1'b0);
        send_desc(32'h1000, 32'd16384);
        wait_done();

        // Two beats straddling a 4 KB page: split into two single-beat bursts.
        push_req(32'h0FC0, 8'd0, ONES, ONES, 1'b0);
        push_req(32'h1000, 8'd0, ONES, ONES, 1'b1);
        push_done(1'b0);
        send_desc(32'h0FC0, 32'd128);
        wait_done();

        // Unaligned head and tail in a two-beat burst.
        push_req(32'h1000, 8'd1, 64'hFFFF_FFFF_FFFF_0000, 64'h000F_FFFF_FFFF_FFFF, 1'b1);
        push_done(1'b0);
        send_desc(32'h1010, 32'd100);
        wait_done();

        // Unaligned head cut short by the page boundary.
        push_req(32'h0FC0, 8'd0, 64'hFFFF_0000_0000_0000, 64'hFFFF_0000_0000_0000, 1'b0);
        push_req(32'h1000, 8'd0, ONES, ONES, 1'b1);
        push_done(1'b0);
        send_desc(32'h0FF0, 32'd80);
        wait_done();

        // Bytes entirely inside one beat: both strobes are the AND of head and tail.
        push_req(32'h2000, 8'd0, 64'h0000_0000_0000_0FF0, 64'h0000_0000_0000_0FF0, 1'b1);
        push_done(1'b0);
        send_desc(32'h2004, 32'd8);
        wait_done();

        // Outstanding cap with a stalled request first.
        auto_rsp    = 1'b0;
        req_ready_i = 1'b0;
        push_req(32'h1000, 8'd63, ONES, ONES, 1'b0);
        push_req(32'h2000, 8'd63, ONES, ONES, 1'b0);
        push_req(32'h3000, 8'd63, ONES, ONES, 1'b0);
        push_req(32'h4000, 8'd63, ONES, ONES, 1'b1);
        push_done(1'b0);
        base = hs_count;
        send_desc(32'h1000, 32'd16384);
        n = 0;
        while (!req_valid_o && n < 50) begin
            wait_cycles(1);
            n++;
        end
        check("stall_seen", 64'(req_valid_o), 64'd1);
        wait_cycles(3);
        req_ready_i = 1'b1;
        wait_cycles(12);
        check("cap_issued",    64'(hs_count - base), 64'd2);
        check("cap_valid_low", 64'(req_valid_o), 64'd0);
        grant(1);
        wait_cycles(12);
        check("cap_third",     64'(hs_count - base), 64'd3);
        auto_rsp = 1'b1;
        wait_done();

        // Zero-byte descriptor: done one cycle after accept, no request.
        push_done(1'b0);
        send_desc(32'h5000, 32'd0);
        @(negedge clk);
        check("zero_done_early", 64'(done_o), 64'd0);
        @(negedge clk);
        check("zero_done",       64'(done_o), 64'd1);
        check("zero_aborted",    64'(aborted_o), 64'd0);
        wait_done();

        // Abort after the first burst handshake, with that burst still outstanding.
        auto_rsp = 1'b0;
        push_req(32'h1000, 8'd63, ONES, ONES, 1'b0);
        push_done(1'b1);
        base = hs_count;
        send_desc(32'h1000, 32'd16384);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_valid_o && req_ready_i) && n < 50);
        abort_i = 1'b1;
        wait_cycles(6);
        check("abort_hs",     64'(hs_count - base), 64'd1);
        check("abort_no_req", 64'(req_valid_o), 64'd0);
        check("abort_busy",   64'(busy_o), 64'd1);
        check("abort_wait",   64'(done_count), 64'(done_target - 1));
        grant(1);
        wait_done();
        abort_i = 1'b0;

        // Asynchronous reset in SPLIT with one burst outstanding and one presented.
        push_req(32'h1000, 8'd63, ONES, ONES, 1'b0);
        base = hs_count;
        send_desc(32'h1000, 32'd16384);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_valid_o && req_ready_i) && n < 50);
        @(posedge clk);
        #1 req_ready_i = 1'b0;
        wait_cycles(2);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid",      64'(req_valid_o), 64'd0);
        check("mid_rst_busy",       64'(busy_o), 64'd0);
        check("mid_rst_desc_ready", 64'(desc_ready_o), 64'd0);
        check("mid_rst_addr",       64'(req_addr_o), 64'd0);
        wait_cycles(2);
        #1 rst = 1'b0;
        req_ready_i = 1'b1;
        auto_rsp    = 1'b1;
        wait_cycles(3);
        check("post_rst_ready", 64'(desc_ready_o), 64'd1);
        check("post_rst_done",  64'(done_count), 64'(done_target));

        // Full descriptor after reset completes, so the outstanding count restarted at 0.
        push_req(32'h1000, 8'd63, ONES, ONES, 1'b0);
        push_req(32'h2000, 8'd63, ONES, ONES, 1'b0);
        push_req(32'h3000, 8'd63, ONES, ONES, 1'b0);
        push_req(32'h4000, 8'd63, ONES, ONES, 1'b1);
        push_done(1'b0);
        send_desc(32'h1000, 32'd16384);
        wait_done();

        wait_cycles(4);
        check("exp_req_empty",  64'(exp_req.size()), 64'd0);
        check("exp_done_empty", 64'(exp_done.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
